traffic_light_ctrl: RTL
=======================

Name: traffic_light_ctrl

Overview:
Two-direction (NS/EW) intersection controller with parametrised phase durations, a pedestrian-request shortening feature, a night flashing mode and a two-digit 7-segment countdown of the current phase.
- All timing is derived from one 1 s tick, produced by a prescaler from sys_clk.
- Drives the board's active-low lamp outputs and two common-anode digits directly.
- Successor to the single-direction fixed-sequence lamp/countdown block.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz; tick period = CLK_FREQ/TICK_DIV cycles (must be ≥2).
TICK_DIV, 1, tick-rate multiplier for simulation; 1 = 1 s tick.
T_GREEN, 25, green duration in seconds (1..99).
T_YELLOW, 3, yellow duration in seconds (1..99).
T_ALLRED, 2, all-red clearance duration in seconds (1..99).
T_PED_MIN, 5, remaining green after a pedestrian request (1..T_GREEN).

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous reset, active-low.
en  in  1  1 = run; 0 = freeze phase and countdown, prescaler keeps counting.
ped_req  in  1  pedestrian button, synchronous, level or pulse; any cycle high sets the request latch.
night_mode  in  1  request for night flashing mode.
ns_light  out  3  NS lamps {R,Y,G}, active-low.
ew_light  out  3  EW lamps {R,Y,G}, active-low.
seg_tens  out  7  tens digit {a,b,c,d,e,f,g}, active-low.
seg_ones  out  7  ones digit, same encoding as seg_tens.
phase  out  3  current state code, for debug and verification.

Behaviour:
- Prescaler: counter 0..CLK_FREQ/TICK_DIV-1. tick is a one-cycle pulse at terminal count. Reset clears the counter to 0.
- Effective tick: tick & en.
- States and codes:
  - NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, NIGHT=6.
  - Normal cycle: NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B→NS_GREEN.
- remaining: 7-bit register.
  - Loaded with the new state's duration on entry.
  - On each effective tick: if remaining==1, transition; else decrement.
  - Each state therefore displays N..1 and lasts exactly N ticks.
- Pedestrian request:
  - req_latch is set by ped_req in any state.
  - In a GREEN state with req_latch=1 and remaining>T_PED_MIN, the next effective tick loads remaining=T_PED_MIN instead of decrementing.
  - req_latch clears on entry to either YELLOW state.
  - If ped_req is asserted in the same cycle as that clear, the set wins.
- Night mode:
  - night_mode is sampled only at the ALLRED_A or ALLRED_B terminal tick; if high, go to NIGHT instead of the next green.
  - In NIGHT:
    - Both yellows toggle on every effective tick, starting on.
    - R and G are off.
    - Digits are blank (7'h7F).
    - remaining is unused.
  - At an effective tick in NIGHT with night_mode=0: go to ALLRED_B, load T_ALLRED, yellows off.
  - req_latch is cleared in NIGHT.
- Lamp decode (active-low 0 = on):
  - Each GREEN: own G on, other R on.
  - Each YELLOW: own Y on, other R on.
  - ALLRED: both R on.
- Digits:
  - tens = remaining/10, ones = remaining%10.
  - Tens digit is blanked when tens==0.
  - Segment codes, bit6=a..bit0=g:
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
    - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Latency: all outputs are registered, one cycle after a state/remaining update.
- Reset (async, any time, including mid-phase):
  - state=ALLRED_B, remaining=T_ALLRED, req_latch=0, prescaler=0.
  - ns_light=ew_light=3'b011.
  - seg_tens=seg_ones=7'h7F, phase=5.
- Simultaneous events:
  - en=0 masks tick entirely; no decrement, shortening or transition.
  - Pedestrian shortening and a remaining==1 transition cannot coincide, because T_PED_MIN≥1.

Decomposition:
- Package traffic_pkg holds:
  - state enum/codes;
  - lamp constants LAMP_RED=3'b011, LAMP_YEL=3'b101, LAMP_GRN=3'b110, LAMP_OFF=3'b111;
  - SEG_BLANK;
  - function bcd_to_seg(4-bit)→7-bit.
- One sub-module, tick_gen: parameter DIV; ports sys_clk, sys_rst_n, tick. Contains the prescaler.
- FSM, countdown, request latch and output decode stay in the top.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=100, TICK_DIV=10, so tick=10 cycles.
- Reset then full cycle, en=1: phase sequence 5,0,1,2,3,4,5 with durations 2,25,3,2,25,3,2 ticks; NS_GREEN shows ns_light=110, ew_light=011, digits "25" down to "1" with tens blank below 10.
- ped_req pulse at NS_GREEN remaining=20: next tick remaining=5, then 4..1, then NS_YELLOW. ped_req at remaining=4: no shortening. Latch is clear in EW_GREEN, which runs a full 25.
- en=0 for 50 cycles mid-EW_GREEN at remaining=12: remaining, phase and lamps hold; after en=1, countdown resumes at 12.
- night_mode=1 raised during NS_GREEN: cycle continues to ALLRED_A end, then phase=6, ns/ew_light alternate 101/111 per tick, digits 7F/7F. Dropping night_mode gives ALLRED_B (2 ticks) then NS_GREEN.
- Async reset asserted mid-NS_YELLOW between clock edges: outputs go immediately to 011/011/7F/7F and phase=5. After release, first transition occurs after 2 ticks.
- Digit encoding sweep: durations forced via parameters T_GREEN=99 and T_GREEN=10. Check tens/ones segment codes against the table for 99, 10, 9 and 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-direction intersection controller:
// state codes, active-low lamp patterns and the 7-segment digit decoder.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    NIGHT     = 3'd6
  } state_t;

  // Lamp bundles are {R,Y,G}; a 0 lights the lamp.
  localparam logic [2:0] LAMP_RED = 3'b011;
  localparam logic [2:0] LAMP_YEL = 3'b101;
  localparam logic [2:0] LAMP_GRN = 3'b110;
  localparam logic [2:0] LAMP_OFF = 3'b111;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Common-anode digit, bit6 = segment a ... bit0 = segment g.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    bcd_to_seg = 7'b0000001;
      4'd1:    bcd_to_seg = 7'b1001111;
      4'd2:    bcd_to_seg = 7'b0010010;
      4'd3:    bcd_to_seg = 7'b0000110;
      4'd4:    bcd_to_seg = 7'b1001100;
      4'd5:    bcd_to_seg = 7'b0100100;
      4'd6:    bcd_to_seg = 7'b0100000;
      4'd7:    bcd_to_seg = 7'b0001111;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0000100;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every DIV sys_clk cycles.
// It never stops, so freezing the controller does not disturb the tick phase.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection controller: phase FSM with per-phase countdown,
// pedestrian shortening of green, night flashing and a two-digit display.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_DIV  = 1,
  parameter int T_GREEN   = 25,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 2,
  parameter int T_PED_MIN = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic [2:0] phase
);

  localparam logic [6:0] D_GREEN  = 7'(T_GREEN);
  localparam logic [6:0] D_YELLOW = 7'(T_YELLOW);
  localparam logic [6:0] D_ALLRED = 7'(T_ALLRED);
  localparam logic [6:0] D_PED    = 7'(T_PED_MIN);

  logic       tick;
  logic       eff_tick;
  state_t     state;
  logic [6:0] remaining;
  logic       req_latch;
  logic       night_yel;
  logic       is_green;
  logic       enter_yellow;

  logic [6:0] tens_val;
  logic [6:0] ones_val;
  logic [2:0] ns_next;
  logic [2:0] ew_next;
  logic [6:0] tens_next;
  logic [6:0] ones_next;

  tick_gen #(
    .DIV(CLK_FREQ / TICK_DIV)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tick     (tick)
  );

  assign eff_tick     = tick & en;
  assign is_green     = (state == NS_GREEN) || (state == EW_GREEN);
  assign enter_yellow = eff_tick && is_green && (remaining == 7'd1);

  assign tens_val = remaining / 7'd10;
  assign ones_val = remaining % 7'd10;

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    ns_next   = LAMP_RED;
    ew_next   = LAMP_RED;
    tens_next = (tens_val == 7'd0) ? SEG_BLANK : bcd_to_seg(tens_val[3:0]);
    ones_next = bcd_to_seg(ones_val[3:0]);
    case (state)
      NS_GREEN:  ns_next = LAMP_GRN;
      NS_YELLOW: ns_next = LAMP_YEL;
      EW_GREEN:  ew_next = LAMP_GRN;
      EW_YELLOW: ew_next = LAMP_YEL;
      NIGHT: begin
        ns_next   = night_yel ? LAMP_YEL : LAMP_OFF;
        ew_next   = night_yel ? LAMP_YEL : LAMP_OFF;
        tens_next = SEG_BLANK;
        ones_next = SEG_BLANK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ALLRED_B;
      remaining <= D_ALLRED;
      req_latch <= 1'b0;
      night_yel <= 1'b0;
      ns_light  <= LAMP_RED;
      ew_light  <= LAMP_RED;
      seg_tens  <= SEG_BLANK;
      seg_ones  <= SEG_BLANK;
      phase     <= ALLRED_B;
    end else begin
      ns_light <= ns_next;
      ew_light <= ew_next;
      seg_tens <= tens_next;
      seg_ones <= ones_next;
      phase    <= state;

      // A press in the same cycle as the clear must survive.
      if (ped_req)                                req_latch <= 1'b1;
      else if (enter_yellow || (state == NIGHT))  req_latch <= 1'b0;

      if (eff_tick) begin
        case (state)
          NS_GREEN, EW_GREEN: begin
            if (remaining == 7'd1) begin
              state     <= (state == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
              remaining <= D_YELLOW;
            end else if (req_latch && (remaining > D_PED)) begin
              remaining <= D_PED;
            end else begin
              remaining <= remaining - 7'd1;
            end
          end
          NS_YELLOW, EW_YELLOW: begin
            if (remaining == 7'd1) begin
              state     <= (state == NS_YELLOW) ? ALLRED_A : ALLRED_B;
              remaining <= D_ALLRED;
            end else begin
              remaining <= remaining - 7'd1;
            end
          end
          ALLRED_A, ALLRED_B: begin
            if (remaining == 7'd1) begin
              if (night_mode) begin
                state     <= NIGHT;
                night_yel <= 1'b1;
              end else begin
                state     <= (state == ALLRED_A) ? EW_GREEN : NS_GREEN;
                remaining <= D_GREEN;
              end
            end else begin
              remaining <= remaining - 7'd1;
            end
          end
          NIGHT: begin
            if (!night_mode) begin
              state     <= ALLRED_B;
              remaining <= D_ALLRED;
              night_yel <= 1'b0;
            end else begin
              night_yel <= ~night_yel;
            end
          end
          default: begin
            state     <= ALLRED_B;
            remaining <= D_ALLRED;
            night_yel <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
